// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared opcodes, field positions and IF/ID state type
package pipe_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  // JR/JALR are R-type; they are told apart by the funct field
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RS_MSB  = 25;
  localparam int RS_LSB  = 21;
  localparam int RT_MSB  = 20;
  localparam int RT_LSB  = 16;
  localparam int RD_MSB  = 15;
  localparam int RD_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int TGT_MSB = 25;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } if_id_state_t;

  // Opcodes that read rt as a source operand (others write it or ignore it)
  function automatic logic uses_rt(input logic [5:0] opcode);
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt = 1'b1;
      default:                         uses_rt = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic [5:0] id_opcode,
  input  logic       idex_memread,
  input  logic [4:0] idex_rt,
  output logic       hz
);

  logic rt_src;
  logic rs_match;
  logic rt_match;

  assign rt_src   = uses_rt(id_opcode);
  assign rs_match = (idex_rt == id_rs);
  assign rt_match = rt_src && (idex_rt == id_rt);

  // r0 is hardwired zero, so a load into it never creates a dependency
  assign hz = id_valid && idex_memread && (idex_rt != 5'd0) && (rs_match || rt_match);

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with stall, flush and counters
module if_id_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  if_addr,
  input  logic [INSTR_W-1:0] if_instr,
  input  logic               redirect,
  input  logic               idex_memread,
  input  logic [4:0]         idex_rt,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic [ADDR_W-1:0]  id_pc_plus1,
  output logic               id_valid,
  output logic [5:0]         id_opcode,
  output logic [4:0]         id_rs,
  output logic [4:0]         id_rt,
  output logic [4:0]         id_rd,
  output logic [15:0]        id_imm16,
  output logic [25:0]        id_tinstr,
  output logic               pc_hold,
  output logic               idex_bubble,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
  if_id_state_t       state_q, state_d;
  logic               hz;
  logic               stall_now;

  assign id_instr    = instr_q;
  assign id_pc       = pc_q;
  assign id_pc_plus1 = pc_q + ADDR_W'(1);
  assign id_valid    = valid_q;
  assign id_opcode   = instr_q[OPC_MSB:OPC_LSB];
  assign id_rs       = instr_q[RS_MSB:RS_LSB];
  assign id_rt       = instr_q[RT_MSB:RT_LSB];
  assign id_rd       = instr_q[RD_MSB:RD_LSB];
  assign id_imm16    = instr_q[IMM_MSB:0];
  assign id_tinstr   = instr_q[TGT_MSB:0];
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

  load_use_detect u_hz (
    .id_valid     (valid_q),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_opcode    (id_opcode),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .hz           (hz)
  );

  // A redirect squashes the wrong-path instruction, so it overrides any stall
  assign stall_now = hz && !redirect;

  // FSM: track stall episodes; hazard is re-evaluated every cycle in either state
  always_comb begin
    state_d     = state_q;
    pc_hold     = 1'b0;
    idex_bubble = 1'b0;
    case (state_q)
      RUN: begin
        pc_hold     = stall_now;
        idex_bubble = stall_now;
        if (stall_now) state_d = STALL;
      end
      STALL: begin
        pc_hold     = stall_now;
        idex_bubble = stall_now;
        if (!stall_now) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Next IF/ID contents and saturating counters: redirect > hazard > capture
  always_comb begin
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (redirect) begin
      instr_d = INSTR_W'(NOP_INSTR);
      valid_d = 1'b0;
      pc_d    = if_addr;
      if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hz) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      instr_d = if_instr;
      pc_d    = if_addr;
      valid_d = 1'b1;
    end
  end

  // State registers, cleared immediately when reset drops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_q     <= INSTR_W'(NOP_INSTR);
      pc_q        <= '0;
      valid_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      state_q     <= RUN;
    end else begin
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      state_q     <= state_d;
    end
  end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed scoreboard bench for if_id_stage
module tb_if_id_stage;

  logic        clk;
  logic        reset;
  logic [29:0] if_addr;
  logic [31:0] if_instr;
  logic        redirect;
  logic        idex_memread;
  logic [4:0]  idex_rt;
  logic [31:0] id_instr;
  logic [29:0] id_pc;
  logic [29:0] id_pc_plus1;
  logic        id_valid;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [15:0] id_imm16;
  logic [25:0] id_tinstr;
  logic        pc_hold;
  logic        idex_bubble;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  if_id_stage dut (
    .clk          (clk),
    .reset        (reset),
    .if_addr      (if_addr),
    .if_instr     (if_instr),
    .redirect     (redirect),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .id_instr     (id_instr),
    .id_pc        (id_pc),
    .id_pc_plus1  (id_pc_plus1),
    .id_valid     (id_valid),
    .id_opcode    (id_opcode),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rd        (id_rd),
    .id_imm16     (id_imm16),
    .id_tinstr    (id_tinstr),
    .pc_hold      (pc_hold),
    .idex_bubble  (idex_bubble),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] pc;
    logic [31:0] instr;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_id(input logic [29:0] pc, input logic [31:0] instr, input logic valid);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.valid = valid;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [29:0] addr, input logic [31:0] instr);
    if_addr  = addr;
    if_instr = instr;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_id_pc", id_pc, e.pc);
      chk("sb_id_instr", id_instr, e.instr);
      chk("sb_id_valid", id_valid, e.valid);
    end
  endtask

  initial begin
    reset        = 1'b1;
    redirect     = 1'b0;
    idex_memread = 1'b0;
    idex_rt      = 5'd0;
    drive(30'd0, 32'h0);
    #2 reset = 1'b0;

    // reset held for two cycles
    step();
    step();
    chk("rst_valid", id_valid, 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    chk("rst_pc_hold", pc_hold, 0);
    chk("rst_bubble", idex_bubble, 0);

    // stream three instructions
    reset = 1'b1;
    drive(30'd0, 32'h8C08_0004); expect_id(30'd0, 32'h8C08_0004, 1'b1);
    #1 chk("stream_hold0", pc_hold, 0);
    step();
    drive(30'd1, 32'h0109_4020); expect_id(30'd1, 32'h0109_4020, 1'b1);
    #1 chk("stream_hold1", pc_hold, 0);
    step();
    chk("add_rs", id_rs, 8);
    chk("add_rt", id_rt, 9);
    chk("add_rd", id_rd, 8);
    chk("add_imm16", id_imm16, 16'h4020);
    chk("add_tinstr", id_tinstr, 26'h109_4020);
    chk("add_pc_plus1", id_pc_plus1, 2);
    drive(30'd2, 32'h0); expect_id(30'd2, 32'h0, 1'b1);
    #1 chk("stream_hold2", pc_hold, 0);
    step();

    // load-use on rs
    drive(30'd3, 32'h0109_4020); expect_id(30'd3, 32'h0109_4020, 1'b1);
    step();
    drive(30'd4, 32'h0009_4020);
    idex_memread = 1'b1;
    idex_rt      = 5'd8;
    #1;
    chk("lu_pc_hold", pc_hold, 1);
    chk("lu_bubble", idex_bubble, 1);
    expect_id(30'd3, 32'h0109_4020, 1'b1);
    step();
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_still_hold", pc_hold, 1);
    idex_memread = 1'b0;
    #1 chk("lu_released", pc_hold, 0);
    expect_id(30'd4, 32'h0009_4020, 1'b1);
    step();

    // load into r0 never stalls, even though id_rs is r0
    idex_memread = 1'b1;
    idex_rt      = 5'd0;
    #1 chk("r0_no_hold", pc_hold, 0);

    // ADDI does not read rt
    idex_memread = 1'b0;
    drive(30'd5, 32'h2109_0005); expect_id(30'd5, 32'h2109_0005, 1'b1);
    step();
    idex_memread = 1'b1;
    idex_rt      = 5'd9;
    #1 chk("addi_rt_no_hold", pc_hold, 0);

    // SW reads rt: hazard, then redirect overrides it
    idex_memread = 1'b0;
    drive(30'd6, 32'hAD09_0000); expect_id(30'd6, 32'hAD09_0000, 1'b1);
    step();
    idex_memread = 1'b1;
    idex_rt      = 5'd9;
    #1 chk("sw_rt_hold", pc_hold, 1);
    redirect = 1'b1;
    drive(30'h20, 32'hDEAD_BEEF);
    #1;
    chk("redir_hold", pc_hold, 0);
    chk("redir_bubble", idex_bubble, 0);
    expect_id(30'h20, 32'h0, 1'b0);
    step();
    chk("redir_flush_cnt", flush_cnt, 1);
    chk("redir_stall_cnt", stall_cnt, 1);
    chk("redir_opcode", id_opcode, 0);
    chk("redir_tinstr", id_tinstr, 0);

    // pc_plus1 wrap
    redirect     = 1'b0;
    idex_memread = 1'b0;
    drive(30'h3FFF_FFFF, 32'h0800_0010); expect_id(30'h3FFF_FFFF, 32'h0800_0010, 1'b1);
    step();
    chk("wrap_pc_plus1", id_pc_plus1, 0);

    // flush counter saturation (65536 flushes in total)
    redirect = 1'b1;
    for (int i = 0; i < 65533; i++) begin
      @(posedge clk);
    end
    #1 chk("sat_flush_fffe", flush_cnt, 16'hFFFE);
    step();
    chk("sat_flush_ffff", flush_cnt, 16'hFFFF);
    step();
    chk("sat_flush_hold", flush_cnt, 16'hFFFF);

    // async reset in the middle of a stall
    redirect = 1'b0;
    drive(30'd7, 32'h0109_4020); expect_id(30'd7, 32'h0109_4020, 1'b1);
    step();
    idex_memread = 1'b1;
    idex_rt      = 5'd8;
    expect_id(30'd7, 32'h0109_4020, 1'b1);
    step();
    chk("mid_stall_hold", pc_hold, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_valid", id_valid, 0);
    chk("async_instr", id_instr, 0);
    chk("async_pc", id_pc, 0);
    chk("async_stall_cnt", stall_cnt, 0);
    chk("async_flush_cnt", flush_cnt, 0);
    chk("async_pc_hold", pc_hold, 0);
    chk("async_bubble", idex_bubble, 0);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register between the fetch unit and decode.
- Captures the word address and instruction word each cycle.
- Splits the instruction into the fields that decode and fetch need: opcode, rs, rt, rd, imm16, 26-bit jump target.
- Owns load-use hazard detection (holds PC and IF/ID, bubbles ID/EX), redirect flushing, and saturating stall/flush counters.

Parameters:
- ADDR_W, 30, word-address width (byte address bits [31:2]).
- INSTR_W, 32, instruction width.
- CNT_W, 16, width of the stall and flush performance counters.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; 0 resets all state immediately.
- if_addr  input  ADDR_W  word address of the instruction currently being fetched (fetch unit addr[31:2]).
- if_instr  input  INSTR_W  instruction memory read data for if_addr; combinational, same cycle.
- redirect  input  1  EX resolved a taken branch, jump or jump-register; younger instruction in IF/ID is wrong-path.
- idex_memread  input  1  instruction in ID/EX is a load.
- idex_rt  input  5  destination register of that load.
- id_instr  output  INSTR_W  registered instruction word.
- id_pc  output  ADDR_W  registered word address.
- id_pc_plus1  output  ADDR_W  id_pc+1, modulo 2^ADDR_W.
- id_valid  output  1  id_instr is a real instruction, not a bubble.
- id_opcode  output  6  id_instr[31:26].
- id_rs  output  5  id_instr[25:21].
- id_rt  output  5  id_instr[20:16].
- id_rd  output  5  id_instr[15:11].
- id_imm16  output  16  id_instr[15:0]; drives fetch imm16.
- id_tinstr  output  26  id_instr[25:0]; drives fetch jump target.
- pc_hold  output  1  combinational; 1 = fetch must not update PC this cycle.
- idex_bubble  output  1  combinational; 1 = ID/EX captures a NOP this cycle.
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles.
- flush_cnt  output  CNT_W  saturating count of flush events.

Behaviour:
- Reset (reset=0, asynchronous):
  - id_instr=NOP (32'h0), id_pc=0, id_valid=0, both counters=0, state=RUN.
  - pc_hold=0 and idex_bubble=0 while in reset.
  - On reset release, the first rising edge captures normally.
- Hazard condition (comb) `hz`: all of
  - id_valid=1,
  - idex_memread=1,
  - idex_rt!=0,
  - and either (idex_rt==id_rs) or (idex_rt==id_rt and uses_rt).
  - uses_rt = opcode in {R-type 0x00, BEQ 0x04, BNE 0x05, SW 0x2B}.
- Priority: redirect > hz > normal capture.
- Per-edge actions:
  - redirect=1: id_instr<=NOP, id_valid<=0, id_pc<=if_addr; flush_cnt++. Any concurrent hazard is discarded; pc_hold=0, idex_bubble=0.
  - hz=1 (no redirect): IF/ID holds all fields; pc_hold=1; idex_bubble=1; stall_cnt++.
  - Otherwise: id_instr<=if_instr, id_pc<=if_addr, id_valid<=1.
- State machine, two states:
  - RUN: normal.
  - STALL: entered on the edge where hz=1 and redirect=0.
  - In STALL, hz is re-evaluated each cycle. Because the load advances out of ID/EX, stalls last exactly 1 cycle unless EX holds.
  - STALL returns to RUN on the first edge where hz=0 or redirect=1.
  - State is observable only through pc_hold timing; not exported.
- Latency: if_instr appears on id_* one clock after the capture edge.
- Field outputs are pure slices of id_instr; a bubble yields all-zero fields.
- id_pc_plus1 uses a 30-bit add; 0x3FFFFFFF+1 wraps to 0.
- Counters saturate at 2^CNT_W-1; no wrap.
- A bubble (id_valid=0) never raises hz.

Decomposition:
- Package pipe_pkg:
  - opcode constants OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_LW, OP_J, OP_JR-class.
  - NOP_INSTR constant.
  - Field-position localparams.
  - Enum if_id_state_t {RUN, STALL}.
- Sub-module load_use_detect (combinational):
  - inputs: id_valid, id_rs, id_rt, id_opcode, idex_memread, idex_rt.
  - output: hz.
  - Reused later by forwarding logic.

Test Plan:
- Reset then stream:
  - Stimulus: reset=0 for 2 cycles, then feed addr 0,1,2 with instr 0x8C080004, 0x01094020, 0x00000000; idex_memread=0.
  - Response: id_valid=0 during reset; next 3 cycles id_pc=0,1,2 and id_instr matches; pc_hold never asserts.
- Load-use on rs:
  - Stimulus: id_instr=0x01094020 (add, rs=8), idex_memread=1, idex_rt=8.
  - Response: pc_hold=1 and idex_bubble=1 for one cycle; id_instr held; stall_cnt=1.
- No hazard on r0 or non-rt user:
  - Stimulus A: idex_rt=0 → pc_hold=0.
  - Stimulus B: ADDI (0x08) with rt matching idex_rt → pc_hold=0.
- Redirect concurrent with hazard:
  - Stimulus: redirect=1 and hz=1 on the same cycle.
  - Response: pc_hold=0; next cycle id_valid=0 and id_instr=0; flush_cnt=1; stall_cnt unchanged.
- Wrap and saturation:
  - Stimulus A: if_addr=0x3FFFFFFF → id_pc_plus1=0.
  - Stimulus B: force 65536 flushes → flush_cnt=0xFFFF.
- Async reset mid-stall:
  - Stimulus: drop reset between edges while pc_hold=1.
  - Response: all outputs reset immediately without waiting for clk.
